// File: rtl/global_avg_pool_stream.sv
// Global average pool: sums each channel over the IMG_H x IMG_W frame, then streams CHANNELS rounded averages.
// Output k is registered 1+k cycles after the last input; in_ready drops during drain, outputs have no backpressure.
module global_avg_pool_stream #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int CHANNELS = 96,
  parameter int IMG_H    = 7,
  parameter int IMG_W    = 7,
  parameter logic [16:0] RECIP = 17'((65536 + (IMG_H * IMG_W) / 2) / (IMG_H * IMG_W))
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        valid_in,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            data_out,
  output logic [$clog2(CHANNELS)-1:0] output_addr,
  output logic                        valid_out
);

  localparam int NPIX   = IMG_H * IMG_W;
  localparam int ACC_W  = WIDTH + $clog2(NPIX);
  localparam int PROD_W = ACC_W + 18;
  localparam int CW     = $clog2(CHANNELS);
  localparam int PW     = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(NPIX - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);
  localparam logic signed [PROD_W-1:0] HALF    = PROD_W'(32768);

  if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
    $error("FRAC must lie in [0, WIDTH)");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                   state_q;
  logic [CW-1:0]            ch_q;
  logic [CW-1:0]            k_q;
  logic [PW-1:0]            pos_q;
  logic [WIDTH-1:0]         data_out_q;
  logic [CW-1:0]            addr_q;
  logic                     valid_q;
  logic signed [ACC_W-1:0]  acc_q [CHANNELS];

  logic                     accept;
  logic signed [ACC_W-1:0]  din_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] avg_full;
  logic [WIDTH-1:0]         avg_d;

  assign in_ready    = (state_q != DRAIN);
  assign accept      = en && valid_in && in_ready;
  assign din_ext     = ACC_W'($signed(data_in));
  assign data_out    = data_out_q;
  assign output_addr = addr_q;
  assign valid_out   = valid_q;

  // Position 0 overwrites, so the array never needs a clear pass between frames.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      acc_q[ch_q] <= (pos_q == '0) ? din_ext : acc_q[ch_q] + din_ext;
    end
  end

  always_comb begin
    prod     = PROD_W'(acc_q[k_q]) * $signed({{(PROD_W - 17){1'b0}}, RECIP});
    avg_full = (prod + HALF) >>> 16;
    avg_d    = avg_full[WIDTH-1:0];
    if (avg_full > SAT_MAX) begin
      avg_d = {1'b0, {(WIDTH - 1){1'b1}}};
    end else if (avg_full < SAT_MIN) begin
      avg_d = {1'b1, {(WIDTH - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      pos_q      <= '0;
      k_q        <= '0;
      data_out_q <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
    end else if (!en) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE, ACCUM: begin
          if (valid_in) begin
            state_q <= ACCUM;
            if (ch_q == CH_LAST) begin
              ch_q <= '0;
              if (pos_q == POS_LAST) begin
                pos_q   <= '0;
                state_q <= DRAIN;
              end else begin
                pos_q <= pos_q + PW'(1);
              end
            end else begin
              ch_q <= ch_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          data_out_q <= avg_d;
          addr_q     <= k_q;
          valid_q    <= 1'b1;
          if (k_q == CH_LAST) begin
            k_q     <= '0;
            state_q <= IDLE;
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_global_avg_pool_stream.sv
// Bench for global_avg_pool_stream: random and directed frames against a per-channel arithmetic average model.
module tb_global_avg_pool_stream;

  localparam int C      = 96;
  localparam int NPIX   = 49;
  localparam int NW     = C * NPIX;
  localparam int RECIP_M = $rtoi(65536.0 / NPIX + 0.5);

  logic              clk;
  logic              rst;
  logic              en;
  logic [15:0]       data_in;
  logic              valid_in;
  logic              in_ready;
  logic [15:0]       data_out;
  logic [6:0]        output_addr;
  logic              valid_out;

  int checks;
  int fails;
  int cyc;
  int acc_edge;
  int first_acc;
  int last_acc;

  logic signed [15:0] frame_v [NW];
  logic signed [15:0] exp_v   [C];

  global_avg_pool_stream dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .output_addr(output_addr),
    .valid_out  (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: mean over positions, scaled by the Q0.16 reciprocal, round half up, clamp.
  task automatic model_frame();
    longint sum;
    longint p;
    longint q;
    for (int c = 0; c < C; c++) begin
      sum = 0;
      for (int pos = 0; pos < NPIX; pos++) sum += longint'(frame_v[pos * C + c]);
      p = sum * RECIP_M + 32768;
      if (p >= 0) q = p / 65536;
      else q = -((-p + 65535) / 65536);
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      exp_v[c] = q[15:0];
    end
  endtask

  task automatic fill_const(input logic signed [15:0] v);
    for (int i = 0; i < NW; i++) frame_v[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NW; i++) frame_v[i] = 16'($urandom);
  endtask

  task automatic send_word(input logic signed [15:0] v);
    int guard;
    guard = 0;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = v;
    while (!(in_ready && en) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      fails++;
      $display("FAIL send_word timeout: in_ready=%b en=%b, required ready within 1000 cycles", in_ready, en);
    end
    @(posedge clk);
    #1;
    acc_edge = cyc;
  endtask

  task automatic send_frame(input string name, input int gap_idx, input int npos, input bit hold);
    for (int i = 0; i < npos * C; i++) begin
      if (i == gap_idx) begin
        en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        en = 1'b1;
      end
      send_word(frame_v[i]);
      if (i == 0) first_acc = acc_edge;
    end
    last_acc = acc_edge;
    if (hold) data_in = 16'd1000;
    else valid_in = 1'b0;
    if (gap_idx < 0) begin
      checks++;
      if (last_acc - first_acc !== npos * C - 1) begin
        fails++;
        $display("FAIL %s input throughput: span %0d edges, required %0d", name, last_acc - first_acc, npos * C - 1);
      end
    end
  endtask

  // Called right after the last accept edge; follows outputs for channels 0..upto-1.
  task automatic drain_walk(input string name, input bit strict, input int gap_k, input int upto);
    int  k;
    int  n;
    bit  gapped;
    k = 0;
    n = 0;
    gapped = 1'b0;
    model_frame();
    while (k < upto && n < 600) begin
      if (k == gap_k && !gapped) begin
        gapped = 1'b1;
        en = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
          n++;
          checks++;
          if (valid_out !== 1'b0) begin
            fails++;
            $display("FAIL %s drain gap valid_out: got %b, required 0", name, valid_out);
          end
        end
        en = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
        if (strict) begin
          checks++;
          if (valid_out !== 1'b1) begin
            fails++;
            $display("FAIL %s valid_out contiguity at k=%0d: got %b, required 1", name, k, valid_out);
          end
          checks++;
          if (in_ready !== (k == C - 1)) begin
            fails++;
            $display("FAIL %s in_ready at k=%0d: got %b, required %b", name, k, in_ready, (k == C - 1));
          end
        end
        if (valid_out === 1'b1) begin
          checks++;
          if (output_addr !== 7'(k)) begin
            fails++;
            $display("FAIL %s output_addr: got %0d, required %0d", name, output_addr, k);
          end
          checks++;
          if (data_out !== exp_v[k]) begin
            fails++;
            $display("FAIL %s data_out ch %0d: got %0d, required %0d", name, k, $signed(data_out), exp_v[k]);
          end
          k++;
        end
      end
    end
    if (k < upto) begin
      checks++;
      fails++;
      $display("FAIL %s drain timeout: got %0d outputs, required %0d", name, k, upto);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    valid_in = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
    checks++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL reset valid_out: got %b, required 0", valid_out); end
    checks++;
    if (data_out !== 16'd0) begin fails++; $display("FAIL reset data_out: got %h, required 0", data_out); end
    checks++;
    if (output_addr !== 7'd0) begin fails++; $display("FAIL reset output_addr: got %0d, required 0", output_addr); end
    rst = 1'b0;
  endtask

  task automatic test_ones();
    fill_const(16'sd256);
    send_frame("ones", -1, NPIX, 1'b0);
    drain_walk("ones", 1'b1, -1, C);
  endtask

  task automatic test_ch0();
    for (int i = 0; i < NW; i++) frame_v[i] = (i % C == 0) ? 16'sd49 : 16'sd0;
    send_frame("ch0", -1, NPIX, 1'b0);
    drain_walk("ch0", 1'b1, -1, C);
  endtask

  task automatic test_neg();
    fill_const(-16'sd256);
    send_frame("neg", -1, NPIX, 1'b0);
    drain_walk("neg", 1'b1, -1, C);
  endtask

  task automatic test_back_to_back();
    int prev_e;
    fill_rand();
    send_frame("b2b_hold", -1, NPIX, 1'b1);
    drain_walk("b2b_hold", 1'b1, -1, C);
    prev_e = last_acc;
    fill_const(16'sd512);
    send_frame("b2b_512", -1, NPIX, 1'b0);
    checks++;
    if (first_acc !== prev_e + C + 1) begin
      fails++;
      $display("FAIL b2b first accept edge: got %0d, required %0d", first_acc, prev_e + C + 1);
    end
    drain_walk("b2b_512", 1'b1, -1, C);
  endtask

  task automatic test_en_gaps();
    fill_rand();
    send_frame("en_gap", 20 * C + 40, NPIX, 1'b0);
    drain_walk("en_gap", 1'b0, 10, C);
  endtask

  task automatic test_rst_mid();
    fill_rand();
    send_frame("rst_mid_part", -1, 30, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid in_ready: got %b, required 1", in_ready); end
    fill_const(16'sd128);
    send_frame("rst_mid_128", -1, NPIX, 1'b0);
    drain_walk("rst_mid_128", 1'b1, -1, C);
  endtask

  task automatic test_rst_drain();
    fill_rand();
    send_frame("rst_drain", -1, NPIX, 1'b0);
    drain_walk("rst_drain", 1'b1, -1, 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL rst_drain valid_out: got %b, required 0", valid_out); end
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_drain in_ready: got %b, required 1", in_ready); end
    checks++;
    if (output_addr !== 7'd0) begin fails++; $display("FAIL rst_drain output_addr: got %0d, required 0", output_addr); end
    checks++;
    if (data_out !== 16'd0) begin fails++; $display("FAIL rst_drain data_out: got %h, required 0", data_out); end
  endtask

  task automatic test_random();
    fill_rand();
    send_frame("random", -1, NPIX, 1'b0);
    drain_walk("random", 1'b1, -1, C);
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst = 1'b1;
    en = 1'b0;
    valid_in = 1'b0;
    data_in = '0;
    test_reset();
    test_ones();
    test_ch0();
    test_neg();
    test_back_to_back();
    test_en_gaps();
    test_rst_mid();
    test_rst_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
